// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush/PC-stack sequencing for the FD and DX pipeline buffers
// Optional macro PIPE_CTRL_STALL_CNT_EN adds o_stall_count (saturating count of PC-hold cycles).
module pipeline_hazard_controller #(
  parameter int REG_W       = 3,
  parameter int STACK_WORDS = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_rs_used,
  input  logic             i_id_rt_used,
  input  logic             i_ex_mem_read,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_write_back,
  input  logic             i_ex_push_pc,
  input  logic             i_ex_pop_pc,
  input  logic             i_ex_branch_taken,
  output logic             o_pc_enable,
  output logic             o_fd_enable,
  output logic             o_fd_flush,
  output logic             o_dx_enable,
  output logic             o_dx_flush,
  output logic [1:0]       o_stack_word,
`ifdef PIPE_CTRL_STALL_CNT_EN
  output logic [15:0]      o_stall_count,
`endif
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STACK    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [1:0] LAST_WORD = 2'(STACK_WORDS - 1);

  state_t     state, state_next;
  logic [1:0] word_cnt;
  logic       seq_is_pop;
  logic       stack_op;
  logic       load_use;

  assign stack_op = i_ex_push_pc | i_ex_pop_pc;
  assign load_use = i_ex_mem_read & i_ex_write_back &
                    ((i_id_rs_used & (i_id_rs == i_ex_rd)) |
                     (i_id_rt_used & (i_id_rt == i_ex_rd)));

  // Word 0 is issued from IDLE in the arrival cycle, so STACK starts at word 1.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      word_cnt   <= 2'd0;
      seq_is_pop <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (stack_op) begin
            word_cnt   <= 2'd1;
            seq_is_pop <= i_ex_pop_pc;
          end else begin
            word_cnt <= 2'd0;
          end
        end
        STACK:   word_cnt <= (word_cnt == LAST_WORD) ? 2'd0 : word_cnt + 2'd1;
        default: word_cnt <= 2'd0;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (stack_op) state_next = STACK;
      STACK:    if (word_cnt == LAST_WORD) state_next = seq_is_pop ? REDIRECT : IDLE;
      REDIRECT: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    o_pc_enable  = 1'b1;
    o_fd_enable  = 1'b1;
    o_fd_flush   = 1'b0;
    o_dx_enable  = 1'b1;
    o_dx_flush   = 1'b0;
    o_stack_word = 2'd0;
    o_busy       = 1'b0;
    if (!i_reset) begin
      case (state)
        IDLE: begin
          // Stack op beats branch beats load-use.
          if (stack_op) begin
            o_busy      = 1'b1;
            o_pc_enable = 1'b0;
            o_fd_enable = 1'b0;
            o_dx_enable = 1'b0;
          end else if (i_ex_branch_taken) begin
            o_fd_flush = 1'b1;
            o_dx_flush = 1'b1;
          end else if (load_use) begin
            o_pc_enable = 1'b0;
            o_fd_enable = 1'b0;
            o_dx_flush  = 1'b1;
          end
        end
        STACK: begin
          o_busy       = 1'b1;
          o_stack_word = word_cnt;
          o_pc_enable  = 1'b0;
          o_fd_enable  = 1'b0;
          o_dx_enable  = 1'b0;
        end
        REDIRECT: begin
          o_fd_flush = 1'b1;
          o_dx_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef PIPE_CTRL_STALL_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_stall_count <= 16'd0;
    end else if (!o_pc_enable && (o_stall_count != 16'hFFFF)) begin
      o_stall_count <= o_stall_count + 16'd1;
    end
  end
`endif

endmodule
